// File: rtl/stack.sv
// stack: LIFO register-file stack with a registered pop output.
//
// Pushes write `in` at the stack pointer; pops present the top entry on
// `out` one cycle later together with a single-cycle `out_valid` strobe.
// Push and pop together replace the top entry, or bypass `in` straight
// to `out` when the stack is empty.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   push       write `in` onto the stack
//   pop        remove the top entry and present it on `out`
//   in         data to push (width bits)
//   out        last popped value, registered
//   out_valid  one-cycle pulse after a successful pop
//   count      number of stored entries, 0..depth
//   empty      count == 0 (decoded)
//   full       count == depth (decoded)
//   overflow   sticky: push refused while full
//   underflow  sticky: pop refused while empty
//
// Build option: define STACK_ERR_EN to implement the sticky overflow and
// underflow flags; otherwise both ports are tied to 0.

module stack #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           in,
    output logic [width-1:0]           out,
    output logic                       out_valid,
    output logic [$clog2(depth):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned CW = $clog2(depth) + 1;
    localparam int unsigned AW = $clog2(depth);

    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_d;
    logic [width-1:0] mem [depth];
    logic [width-1:0] out_d;
    logic             out_valid_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    sp_addr;
    logic [AW-1:0]    top_addr;

`ifdef STACK_ERR_EN
    logic             overflow_d;
    logic             underflow_d;
`endif

    // Occupancy decode straight from the registered pointer.
    assign count    = sp;
    assign empty    = (sp == '0);
    assign full     = (sp == CW'(depth));
    assign sp_addr  = AW'(sp);
    assign top_addr = AW'(sp - CW'(1));

    // Next-state decode for pointer, output register, memory write and flags.
    always_comb begin
        sp_d        = sp;
        out_d       = out;
        out_valid_d = 1'b0;
        we          = 1'b0;
        waddr       = sp_addr;
`ifdef STACK_ERR_EN
        overflow_d  = overflow;
        underflow_d = underflow;
`endif
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    we   = 1'b1;
                    sp_d = sp + CW'(1);
                end else begin
`ifdef STACK_ERR_EN
                    overflow_d = 1'b1;
`endif
                end
            end
            2'b01: begin
                if (!empty) begin
                    out_d       = mem[top_addr];
                    out_valid_d = 1'b1;
                    sp_d        = sp - CW'(1);
                end else begin
`ifdef STACK_ERR_EN
                    underflow_d = 1'b1;
`endif
                end
            end
            2'b11: begin
                out_valid_d = 1'b1;
                if (!empty) begin
                    // Replace top: old top goes out, new data takes its slot.
                    out_d = mem[top_addr];
                    we    = 1'b1;
                    waddr = top_addr;
                end else begin
                    // Empty bypass: nothing stored, data passes through.
                    out_d = in;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            sp        <= sp_d;
            out       <= out_d;
            out_valid <= out_valid_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= in;
        end
    end

`ifdef STACK_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow_d;
            underflow <= underflow_d;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack.sv
// tb_stack: self-checking bench for stack (width 8, depth 4).
// Directed table of {inputs, expected outputs} rows, then randomized
// traffic compared against a queue-based reference model.

module tb_stack;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D) + 1;

`ifdef STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    stack #(.width(W), .depth(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .in        (din),
        .out       (dout),
        .out_valid (out_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: a queue whose back is the stack top.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_out = '0;
    logic         m_vld = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    typedef struct {
        logic          rst;
        logic          psh;
        logic          pp;
        logic [W-1:0]  d;
        logic [W-1:0]  e_out;
        logic          e_vld;
        logic [CW-1:0] e_cnt;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(logic r, logic p, logic q, logic [W-1:0] d,
                                 logic [W-1:0] o, logic v, int c, logic ov, logic un);
        vec_t x;
        x.rst = r; x.psh = p; x.pp = q; x.d = d;
        x.e_out = o; x.e_vld = v; x.e_cnt = CW'(c); x.e_ovf = ov; x.e_unf = un;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_step(input logic r, input logic p, input logic q, input logic [W-1:0] d);
        if (r) begin
            m_q.delete();
            m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (p && q) begin
                m_vld = 1'b1;
                if (m_q.size() == 0) m_out = d;
                else begin
                    m_out = m_q[$];
                    m_q[m_q.size()-1] = d;
                end
            end else if (p) begin
                if (m_q.size() < D) m_q.push_back(d);
                else m_ovf = 1'b1;
            end else if (q) begin
                if (m_q.size() > 0) begin
                    m_out = m_q.pop_back();
                    m_vld = 1'b1;
                end else m_unf = 1'b1;
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise.
    task automatic apply(input logic r, input logic p, input logic q, input logic [W-1:0] d);
        @(negedge clk);
        reset = r; push = p; pop = q; din = d;
        @(posedge clk);
        model_step(r, p, q, d);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] o, input logic v,
                           input logic [CW-1:0] c, input logic ov, input logic un);
        chk({tag, ".out"}, 32'(dout), 32'(o));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
        chk({tag, ".full"}, 32'(full), 32'(c == CW'(D)));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov & ERR_EN));
        chk({tag, ".underflow"}, 32'(underflow), 32'(un & ERR_EN));
    endtask

    initial begin
        // reset, push 3, pop 3
        tbl.push_back(row(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h22, 8'h00, 0, 2, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h33, 8'h00, 0, 3, 0, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h33, 1, 2, 0, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h22, 1, 1, 0, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 8'h00, 8'h11, 0, 0, 0, 0));
        // fill to depth, refused push, drain
        tbl.push_back(row(0, 1, 0, 8'hA0, 8'h11, 0, 1, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'hA1, 8'h11, 0, 2, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'hA2, 8'h11, 0, 3, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'hA3, 8'h11, 0, 4, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'hFF, 8'h11, 0, 4, 1, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'hA3, 1, 3, 1, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'hA2, 1, 2, 1, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'hA1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'hA0, 1, 0, 1, 0));
        // pop while empty, then push/pop
        tbl.push_back(row(0, 0, 1, 8'h00, 8'hA0, 0, 0, 1, 1));
        tbl.push_back(row(0, 1, 0, 8'h05, 8'hA0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h05, 1, 0, 1, 1));
        // replace top
        tbl.push_back(row(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h10, 8'h00, 0, 1, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h20, 8'h00, 0, 2, 0, 0));
        tbl.push_back(row(0, 1, 1, 8'h99, 8'h20, 1, 2, 0, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h99, 1, 1, 0, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h10, 1, 0, 0, 0));
        // empty bypass
        tbl.push_back(row(0, 1, 1, 8'h42, 8'h42, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 8'h00, 8'h42, 0, 0, 0, 0));
        // replace top while full: no overflow
        tbl.push_back(row(0, 1, 0, 8'h01, 8'h42, 0, 1, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h02, 8'h42, 0, 2, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h03, 8'h42, 0, 3, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h04, 8'h42, 0, 4, 0, 0));
        tbl.push_back(row(0, 1, 1, 8'h55, 8'h04, 1, 4, 0, 0));
        tbl.push_back(row(0, 1, 0, 8'h66, 8'h04, 0, 4, 1, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h55, 1, 3, 1, 0));
        // reset wins over push; then underflow check
        tbl.push_back(row(1, 1, 0, 8'h77, 8'h00, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].psh, tbl[i].pp, tbl[i].d);
            chk_vec($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_vld,
                    tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_unf);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic r, p, q;
            logic [W-1:0] d;
            r = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 50);
            d = W'($urandom);
            apply(r, p, q, d);
            chk_vec($sformatf("rnd%0d", n), m_out, m_vld, CW'(m_q.size()), m_ovf, m_unf);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
